// File: rtl/spi_pkg.sv
// Shared SPI frame geometry and transmitter FSM state codes, so the receiver
// and transmitter agree on frame length.
package spi_pkg;

    localparam int DATA_LENGTH = 8;
    localparam int TRAIL_SCK   = 4;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 3'd0;
    localparam spi_state_t ST_SETUP = 3'd1;
    localparam spi_state_t ST_SHIFT = 3'd2;
    localparam spi_state_t ST_HOLD  = 3'd3;
    localparam spi_state_t ST_GAP   = 3'd4;

endpackage

// File: rtl/spi_master_tx_if.sv
// Word handshake plus SPI pins of the transmitter; the "slave" modport is the
// transmitter side, "master" is the system logic feeding it.
interface spi_master_tx_if #(
    parameter int DATA_LENGTH = spi_pkg::DATA_LENGTH
);
    logic [DATA_LENGTH-1:0] data;
    logic                   valid;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic                   sck;
    logic                   ss;
    logic                   mosi;

    modport master (output data, valid, input ready, busy, done, sck, ss, mosi);
    modport slave  (input data, valid, output ready, busy, done, sck, ss, mosi);
endinterface

// File: rtl/spi_clk_div.sv
// Half-period timer for sck: one-cycle tick every CLK_DIV enabled cycles,
// count held at zero while disabled so each enable starts a fresh period.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int            CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == TC);
        cnt_d = cnt_q + 1'b1;
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 word transmitter, LSB first, with trailing dummy sck pulses.
//   state | meaning
//   IDLE  | ready for a word, ss high
//   SETUP | ss low, sck low for one half-period before the first rise
//   SHIFT | DATA_LENGTH data bits then TRAIL_SCK dummy bits (mosi=0)
//   HOLD  | sck low, ss still low for one half-period
//   GAP   | ss high, busy, first cycle carries the done pulse
module spi_master_tx #(
    parameter int DATA_LENGTH = spi_pkg::DATA_LENGTH,
    parameter int CLK_DIV     = 2,
    parameter int TRAIL_SCK   = spi_pkg::TRAIL_SCK,
    parameter int GAP_CYCLES  = 2
) (
    input logic            clk,
    input logic            rst_n,
    spi_master_tx_if.slave bus
);
    import spi_pkg::*;

    localparam int            N        = DATA_LENGTH + TRAIL_SCK;
    localparam int            BW       = $clog2(N + 1);
    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    spi_state_t             state_q, state_d;
    logic [DATA_LENGTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic                   sck_q, sck_d;
    logic                   ss_q, ss_d;
    logic                   done_q, done_d;
    logic                   div_en, tick, accept;

    assign div_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_en),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sck_d     = sck_q;
        ss_d      = ss_q;
        done_d    = 1'b0;
        accept    = bus.valid && (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SETUP;
                    shreg_d   = bus.data;
                    bit_cnt_d = '0;
                    ss_d      = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    sck_d   = 1'b1;
                end
            end
            ST_SHIFT: begin
                // mosi moves only on the falling edge; zeros shift in behind the word
                if (tick) begin
                    if (sck_q) begin
                        sck_d     = 1'b0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = shreg_q >> 1;
                    end else if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        sck_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d   = ST_GAP;
                    ss_d      = 1'b1;
                    done_d    = 1'b1;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sck_q     <= 1'b0;
            ss_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sck_q     <= sck_d;
            ss_q      <= ss_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready = (state_q == ST_IDLE);
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = done_q;
    assign bus.sck   = sck_q;
    assign bus.ss    = ss_q;
    assign bus.mosi  = shreg_q[0];
endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench: dut0 uses the default divider, dut1 runs with CLK_DIV=1.
module tb_spi_master_tx;
    logic clk    = 1'b0;
    logic rst_n0 = 1'b1;
    logic rst_n1 = 1'b1;
    always #5 clk = ~clk;

    spi_master_tx_if #(.DATA_LENGTH(8)) if0 ();
    spi_master_tx_if #(.DATA_LENGTH(8)) if1 ();

    spi_master_tx #(.DATA_LENGTH(8), .CLK_DIV(2), .TRAIL_SCK(4), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n0), .bus(if0));
    spi_master_tx #(.DATA_LENGTH(8), .CLK_DIV(1), .TRAIL_SCK(4), .GAP_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n1), .bus(if1));

    typedef struct {
        int         id;
        logic [7:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    int          low_len[2], rises[2], lead[2], tail[2], hi_run[2], last_hi[2], since_done[2];
    int          done_cnt[2] = '{0, 0};
    logic [11:0] bits[2];
    logic        prev_ss[2], prev_sck[2], held[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 0) ? if0.ready : if1.ready;
    endfunction

    function automatic logic [3:0] snap(input int id);
        return (id == 0) ? {if0.busy, if0.ready, if0.ss, if0.mosi}
                         : {if1.busy, if1.ready, if1.ss, if1.mosi};
    endfunction

    task automatic drive(input int id, input logic v, input logic [7:0] d);
        if (id == 0) begin
            if0.valid = v;
            if0.data  = d;
        end else begin
            if1.valid = v;
            if1.data  = d;
        end
    endtask

    // Receiver model: samples mosi on sck rises, checks framing, pops expectations.
    task automatic mon_step(input int id, input logic rst, input logic ss, input logic sck,
                            input logic mosi, input logic done, input logic ready,
                            input logic busy, input int h);
        logic ss_rise, sck_rise, sck_fall;
        exp_t e;
        if (!rst) begin
            prev_ss[id]    = 1'b1;
            prev_sck[id]   = 1'b0;
            low_len[id]    = 0;
            rises[id]      = 0;
            lead[id]       = 0;
            tail[id]       = 0;
            hi_run[id]     = 0;
            since_done[id] = -1;
            bits[id]       = '0;
            held[id]       = 1'b0;
        end else begin
            ss_rise  = !prev_ss[id] && ss;
            sck_rise = !prev_sck[id] && sck;
            sck_fall = prev_sck[id] && !sck;
            chk("busy_is_not_ready", 32'(busy), 32'(!ready));
            if (done || ss_rise) chk("done_with_ss_rise", 32'(done), 32'(ss_rise));
            if (done) done_cnt[id]++;
            if (since_done[id] >= 0) begin
                since_done[id]++;
                if (ready) begin
                    chk("ready_after_done", 32'(since_done[id]), 32'd2);
                    since_done[id] = -1;
                end
            end
            if (ss) begin
                chk("sck_idle_low", 32'(sck), 32'd0);
                chk("mosi_idle_low", 32'(mosi), 32'd0);
                hi_run[id]++;
                if (ss_rise) begin
                    chk("frame_len", 32'(low_len[id]), 32'(2 * h + 2 * h * 12));
                    chk("sck_rises", 32'(rises[id]), 32'd12);
                    chk("tail_low_ge_h", 32'(tail[id] >= h), 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_dut_id", 32'(id), 32'(e.id));
                        chk("rx_data", 32'(bits[id][7:0]), 32'(e.word));
                        chk("trail_mosi", 32'(bits[id][11:8]), 32'd0);
                    end
                    since_done[id] = 0;
                end
            end else begin
                if (prev_ss[id]) begin
                    last_hi[id] = hi_run[id];
                    hi_run[id]  = 0;
                    low_len[id] = 0;
                    rises[id]   = 0;
                    lead[id]    = 0;
                    tail[id]    = 0;
                    bits[id]    = '0;
                end
                low_len[id]++;
                if (sck_rise) begin
                    if (rises[id] == 0) chk("lead_low_ge_h", 32'(lead[id] >= h), 32'd1);
                    if (rises[id] < 12) bits[id][4'(rises[id])] = mosi;
                    rises[id]++;
                    held[id] = mosi;
                end else if (sck) begin
                    chk("mosi_stable_sck_high", 32'(mosi), 32'(held[id]));
                end else if (rises[id] == 0) begin
                    lead[id]++;
                end else if (sck_fall) begin
                    tail[id] = 1;
                end else begin
                    tail[id]++;
                end
            end
            prev_ss[id]  = ss;
            prev_sck[id] = sck;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, rst_n0, if0.ss, if0.sck, if0.mosi, if0.done, if0.ready, if0.busy, 2);
        mon_step(1, rst_n1, if1.ss, if1.sck, if1.mosi, if1.done, if1.ready, if1.busy, 1);
    end

    task automatic send(input int id, input logic [7:0] w, input bit keep);
        bit ok = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 400; c++) begin
            drive(id, 1'b1, w);
            if (rdy(id)) begin
                exp_q.push_back('{id, w});
                @(posedge clk);
                #1;
                chk("accept_busy_ready_ss_mosi", 32'(snap(id)), 32'({1'b1, 1'b0, 1'b0, w[0]}));
                if (!keep) drive(id, 1'b0, w);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int id);
        bit ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && rdy(id)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_done_in_budget", 32'(ok), 32'd1);
    endtask

    initial begin
        int  dc;
        int  r;
        bit  prev;
        bit  hit;
        logic [7:0] w;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        #2;
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        #1;
        chk("reset_outputs_dut0", 32'({if0.ready, if0.busy, if0.done, if0.sck, if0.ss, if0.mosi}), 32'(6'b100010));
        chk("reset_outputs_dut1", 32'({if1.ready, if1.busy, if1.done, if1.sck, if1.ss, if1.mosi}), 32'(6'b100010));
        repeat (3) @(negedge clk);
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;

        send(0, 8'hA5, 1'b0);
        wait_done(0);

        send(0, 8'h01, 1'b1);
        send(0, 8'h80, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("b2b_ss_high_cycles", 32'(last_hi[0]), 32'd3);
        wait_done(0);

        send(1, 8'hFF, 1'b0);
        wait_done(1);

        // Reset at the 5th sck rise abandons the frame without a done pulse.
        send(0, 8'hC3, 1'b0);
        r    = 0;
        prev = 1'b0;
        hit  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (if0.sck && !prev) r++;
            prev = if0.sck;
            if (r == 5) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reached_5th_rise", 32'(hit), 32'd1);
        rst_n0 = 1'b0;
        #1;
        chk("midframe_reset_outputs", 32'({if0.ready, if0.busy, if0.done, if0.sck, if0.ss, if0.mosi}), 32'(6'b100010));
        exp_q.delete();
        dc = done_cnt[0];
        repeat (3) @(negedge clk);
        rst_n0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_done_on_abort", 32'(done_cnt[0] - dc), 32'd0);
        send(0, 8'h3C, 1'b0);
        wait_done(0);
        chk("done_after_reset_frame", 32'(done_cnt[0] - dc), 32'd1);

        // valid pulsed while busy must be ignored.
        dc = done_cnt[0];
        send(0, 8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        drive(0, 1'b1, 8'h00);
        repeat (4) @(negedge clk);
        drive(0, 1'b0, 8'h00);
        wait_done(0);
        repeat (20) @(negedge clk);
        chk("single_done_ignored_valid", 32'(done_cnt[0] - dc), 32'd1);

        for (int i = 0; i < 100; i++) begin
            w = 8'($urandom);
            send(0, w, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_done(0);
        chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
